// File: rtl/eth_drain_pkg.sv
// Shared types, register map defaults and helpers for the RX drain engine.
package eth_drain_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_POLL_W,
    S_GAP,
    S_LEN,
    S_LEN_W,
    S_RD,
    S_RD_W,
    S_OUT,
    S_ACK
  } state_t;

  localparam logic [63:0] RSR_RECV_DONE_MASK  = 64'h10;
  localparam logic [63:0] RSR_RECV_FIRST_MASK = 64'h0F;

  localparam logic [14:0] RSR_OFFSET_DEF    = 15'h1FF0;
  localparam logic [14:0] RPLR_OFFSET_DEF   = 15'h1FE8;
  localparam logic [14:0] RXBUFF_OFFSET_DEF = 15'h4000;
  localparam logic [14:0] BUF_STRIDE_DEF    = 15'h0800;
  localparam int          MAX_LEN_DEF       = 1536;
  localparam int          POLL_GAP_DEF      = 16;

  // Byte-valid mask of the final beat; a length that is a multiple of 8 fills the beat.
  function automatic logic [7:0] last_keep(input logic [2:0] len_lo);
    logic [8:0] mask;
    mask = (9'd1 << len_lo) - 9'd1;
    return (len_lo == 3'd0) ? 8'hFF : mask[7:0];
  endfunction

endpackage

// File: rtl/eth_drain_outreg.sv
// Stream output holding register: a loaded beat stays put until the consumer takes it.
module eth_drain_outreg (
  input  logic        msoc_clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [7:0]  load_keep,
  input  logic        load_last,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid
);

  // Capture a beat on load; valid drops only after a handshake, payload is never disturbed meanwhile.
  always_ff @(posedge msoc_clk) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (load) begin
      m_tdata  <= load_data;
      m_tkeep  <= load_keep;
      m_tlast  <= load_last;
      m_tvalid <= 1'b1;
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_drain.sv
// Bus master that polls the MAC receive status, streams each frame out and releases the buffer.
//
// state  | meaning
// IDLE   | waiting for enable
// POLL   | read receive status
// POLL_W | status arrives; frame pending -> LEN, else GAP
// GAP    | poll back-off timer
// LEN    | read packet length
// LEN_W  | length arrives; bad length -> ACK (dropped)
// RD     | read one buffer word
// RD_W   | word arrives, loaded into output register
// OUT    | wait for consumer handshake
// ACK    | write status to release the buffer
module eth_rx_drain import eth_drain_pkg::*; #(
  parameter logic [14:0] RSR_OFFSET    = RSR_OFFSET_DEF,
  parameter logic [14:0] RPLR_OFFSET   = RPLR_OFFSET_DEF,
  parameter logic [14:0] RXBUFF_OFFSET = RXBUFF_OFFSET_DEF,
  parameter logic [14:0] BUF_STRIDE    = BUF_STRIDE_DEF,
  parameter int          MAX_LEN       = MAX_LEN_DEF,
  parameter int          POLL_GAP      = POLL_GAP_DEF
) (
  input  logic        msoc_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [14:0] core_lsu_addr,
  output logic [63:0] core_lsu_wdata,
  output logic [7:0]  core_lsu_be,
  output logic        ce_d,
  output logic        we_d,
  input  logic [63:0] framing_rdata,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count,
  output logic        busy
);

  // GAP plus the IDLE re-check together span POLL_GAP cycles, giving a poll period of POLL_GAP+2.
  localparam logic [7:0]  GAP_LOAD  = 8'(POLL_GAP - 2);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  gap_cnt;
  logic [3:0]  buf_id;
  logic [2:0]  len_lo;
  logic [7:0]  words;
  logic [7:0]  idx;
  logic        load;

  logic [10:0] len_in;
  logic        bad_len;
  logic [7:0]  words_in;
  logic        rsr_done;
  logic        is_last;
  logic        hs;
  logic [14:0] buf_base;
  logic [14:0] rd_addr;

  assign len_in   = framing_rdata[10:0];
  assign bad_len  = (len_in == 11'd0) || (12'(len_in) > MAX_LEN_W);
  assign words_in = 8'((12'(len_in) + 12'd7) >> 3);
  assign rsr_done = (framing_rdata & RSR_RECV_DONE_MASK) != 64'd0;
  assign is_last  = (idx == words - 8'd1);
  assign hs       = m_tvalid && m_tready;
  assign buf_base = {11'd0, buf_id} * BUF_STRIDE;
  assign rd_addr  = RXBUFF_OFFSET + buf_base + {4'd0, idx, 3'd0};

  // State register.
  always_ff @(posedge msoc_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (enable) state_nxt = S_POLL;
      S_POLL:   state_nxt = S_POLL_W;
      S_POLL_W: state_nxt = rsr_done ? S_LEN : S_GAP;
      S_GAP:    if (gap_cnt == 8'd0) state_nxt = S_IDLE;
      S_LEN:    state_nxt = S_LEN_W;
      S_LEN_W:  state_nxt = bad_len ? S_ACK : S_RD;
      S_RD:     state_nxt = S_RD_W;
      S_RD_W:   state_nxt = S_OUT;
      S_OUT:    if (hs) state_nxt = m_tlast ? S_ACK : S_RD;
      S_ACK:    state_nxt = S_GAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes, register load and busy flag, all decoded from the current state.
  always_comb begin
    core_lsu_addr  = '0;
    core_lsu_wdata = '0;
    core_lsu_be    = '0;
    ce_d           = 1'b0;
    we_d           = 1'b0;
    load           = 1'b0;
    busy           = !(state == S_IDLE || state == S_GAP);
    unique case (state)
      S_POLL: begin
        ce_d          = 1'b1;
        core_lsu_addr = RSR_OFFSET;
      end
      S_LEN: begin
        ce_d          = 1'b1;
        core_lsu_addr = RPLR_OFFSET;
      end
      S_RD: begin
        ce_d          = 1'b1;
        core_lsu_addr = rd_addr;
      end
      S_RD_W: load = 1'b1;
      S_ACK: begin
        ce_d           = 1'b1;
        we_d           = 1'b1;
        core_lsu_be    = 8'hFF;
        core_lsu_addr  = RSR_OFFSET;
        core_lsu_wdata = {60'd0, buf_id + 4'd1};
      end
      default: ;
    endcase
  end

  // Frame bookkeeping: buffer id, length, word index, back-off timer and counters.
  always_ff @(posedge msoc_clk) begin
    if (reset) begin
      gap_cnt    <= '0;
      buf_id     <= '0;
      len_lo     <= '0;
      words      <= '0;
      idx        <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      unique case (state)
        S_POLL_W: begin
          gap_cnt <= GAP_LOAD;
          if (rsr_done) buf_id <= 4'(framing_rdata & RSR_RECV_FIRST_MASK);
        end
        S_GAP: if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        S_LEN_W: begin
          len_lo <= len_in[2:0];
          words  <= words_in;
          idx    <= '0;
          if (bad_len) drop_count <= drop_count + 16'd1;
        end
        S_OUT: if (hs) begin
          idx <= idx + 8'd1;
          if (m_tlast) pkt_count <= pkt_count + 16'd1;
        end
        S_ACK: gap_cnt <= GAP_LOAD;
        default: ;
      endcase
    end
  end

  eth_drain_outreg u_outreg (
    .msoc_clk  (msoc_clk),
    .reset     (reset),
    .load      (load),
    .load_data (framing_rdata),
    .load_keep (is_last ? last_keep(len_lo) : 8'hFF),
    .load_last (is_last),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid)
  );

endmodule

// File: tb/tb_eth_rx_drain.sv
// Bench for eth_rx_drain: MAC bus responder, frame-level reference model and directed scenarios.
module tb_eth_rx_drain;

  logic        msoc_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [14:0] core_lsu_addr;
  logic [63:0] core_lsu_wdata;
  logic [7:0]  core_lsu_be;
  logic        ce_d;
  logic        we_d;
  logic [63:0] framing_rdata = '0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic        busy;

  always #5 msoc_clk = ~msoc_clk;

  eth_rx_drain dut (
    .msoc_clk       (msoc_clk),
    .reset          (reset),
    .enable         (enable),
    .core_lsu_addr  (core_lsu_addr),
    .core_lsu_wdata (core_lsu_wdata),
    .core_lsu_be    (core_lsu_be),
    .ce_d           (ce_d),
    .we_d           (we_d),
    .framing_rdata  (framing_rdata),
    .m_tdata        (m_tdata),
    .m_tkeep        (m_tkeep),
    .m_tlast        (m_tlast),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  // Frame currently offered by the MAC model (written by the stimulus only).
  int          posted  = 0;
  logic [3:0]  cur_buf = '0;
  logic [10:0] cur_len = '0;
  logic        poll_window = 1'b0;

  // Observations gathered by the monitor (written by the monitor only).
  int          acks_total    = 0;
  int          beats_total   = 0;
  int          stall_cycles  = 0;
  int          rd_idx        = 0;
  int          beat_idx      = 0;
  int          cyc           = 0;
  int          last_rsr_cyc  = -1;
  int          poll_period   = 0;
  int          other_access  = 0;
  int          rsr_in_window = 0;
  logic        rsr_rd;
  logic        rsr_prev      = 1'b0;
  logic        stall_prev    = 1'b0;
  logic [63:0] held_data;
  logic [7:0]  held_keep;
  logic        held_last;
  logic [14:0] first_rd_addr = '0;
  logic [7:0]  last_keep_seen = '0;
  logic [63:0] last_ack_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents the MAC holds at a buffer address: tagged with the address so misreads show up.
  function automatic logic [63:0] buf_word(input logic [14:0] a);
    return {16'hDA7A, 1'b0, a, 1'b1, ~a, 16'h5EED};
  endfunction

  function automatic int exp_words(input int len);
    if (len == 0 || len > 1536) return 0;
    return (len + 7) / 8;
  endfunction

  function automatic logic [14:0] exp_addr(input int b, input int i);
    int v;
    v = (16384 + b * 2048 + i * 8) % 32768;
    return v[14:0];
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int i);
    int k;
    k = (i == exp_words(len) - 1 && len % 8 != 0) ? (1 << (len % 8)) - 1 : 255;
    return k[7:0];
  endfunction

  // MAC side of the bus: read data one cycle after the strobe; receive-done while a frame is unreleased.
  always @(posedge msoc_clk) begin
    if (ce_d && !we_d) begin
      if (core_lsu_addr == 15'h1FF0)
        framing_rdata <= {59'd0, posted > acks_total, cur_buf};
      else if (core_lsu_addr == 15'h1FE8)
        framing_rdata <= {53'd0, cur_len};
      else
        framing_rdata <= buf_word(core_lsu_addr);
    end
  end

  // Monitor: every bus access and stream beat is checked against the frame model.
  always @(negedge msoc_clk) begin
    cyc++;
    rsr_rd = ce_d && !we_d && core_lsu_addr == 15'h1FF0;
    if (reset) begin
      rd_idx     = 0;
      beat_idx   = 0;
      stall_prev = 1'b0;
    end else begin
      if (ce_d && !we_d && !rsr_rd && core_lsu_addr != 15'h1FE8) begin
        check("rd_addr", 64'(core_lsu_addr), 64'(exp_addr(int'(cur_buf), rd_idx)));
        if (rd_idx == 0) first_rd_addr = core_lsu_addr;
        rd_idx++;
      end
      if (ce_d && we_d) begin
        check("ack_addr", 64'(core_lsu_addr), 64'h1FF0);
        check("ack_be", 64'(core_lsu_be), 64'hFF);
        check("ack_wdata", core_lsu_wdata, 64'(4'(cur_buf + 4'd1)));
        last_ack_wdata = core_lsu_wdata;
        acks_total++;
        rd_idx   = 0;
        beat_idx = 0;
      end
      if (rsr_rd) begin
        if (last_rsr_cyc >= 0) poll_period = cyc - last_rsr_cyc;
        last_rsr_cyc = cyc;
      end
      if (poll_window) begin
        if (ce_d && !rsr_rd) other_access++;
        if (rsr_rd) rsr_in_window++;
        check("busy_poll", 64'(busy), 64'(rsr_rd || rsr_prev));
      end else begin
        other_access  = 0;
        rsr_in_window = 0;
      end
      if (m_tvalid) begin
        check("bus_quiet_valid", 64'(ce_d), 64'd0);
        if (stall_prev) begin
          check("hold_tdata", m_tdata, held_data);
          check("hold_tkeep", 64'(m_tkeep), 64'(held_keep));
          check("hold_tlast", 64'(m_tlast), 64'(held_last));
        end
        if (m_tready) begin
          check("beat_expected", 64'(beat_idx < exp_words(int'(cur_len))), 64'd1);
          check("beat_tdata", m_tdata, buf_word(exp_addr(int'(cur_buf), beat_idx)));
          check("beat_tkeep", 64'(m_tkeep), 64'(exp_keep(int'(cur_len), beat_idx)));
          check("beat_tlast", 64'(m_tlast), 64'(beat_idx == exp_words(int'(cur_len)) - 1));
          last_keep_seen = m_tkeep;
          beat_idx++;
          beats_total++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held_data  = m_tdata;
          held_keep  = m_tkeep;
          held_last  = m_tlast;
          stall_cycles++;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
    rsr_prev = rsr_rd && !reset;
  end

  task automatic post_frame(input logic [3:0] b, input logic [10:0] l);
    cur_buf = b;
    cur_len = l;
    posted++;
  endtask

  task automatic wait_acks(input int target, input string name);
    for (int i = 0; i < 3000 && acks_total < target; i++) begin
      @(posedge msoc_clk);
      #2;
    end
    check(name, 64'(acks_total >= target), 64'd1);
  endtask

  task automatic wait_beats(input int target, input string name);
    for (int i = 0; i < 1000 && beats_total < target; i++) begin
      @(posedge msoc_clk);
      #2;
    end
    check(name, 64'(beats_total >= target), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tdata"}, m_tdata, 64'd0);
    check({tag, "_tkeep"}, 64'(m_tkeep), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_ce"}, 64'(ce_d), 64'd0);
    check({tag, "_we"}, 64'(we_d), 64'd0);
    check({tag, "_addr"}, 64'(core_lsu_addr), 64'd0);
    check({tag, "_pkt"}, 64'(pkt_count), 64'd0);
    check({tag, "_drop"}, 64'(drop_count), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  int base;
  int sbase;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge msoc_clk);
    #2;
    check_quiet("reset");
    @(posedge msoc_clk);
    #1;
    reset    = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;

    // 64-byte frame in buffer 0
    base = beats_total;
    post_frame(4'd0, 11'd64);
    wait_acks(1, "t1_ack_seen");
    check("t1_beats", 64'(beats_total - base), 64'd8);
    check("t1_first_addr", 64'(first_rd_addr), 64'h4000);
    check("t1_last_keep", 64'(last_keep_seen), 64'hFF);
    check("t1_ack_wdata", last_ack_wdata, 64'd1);
    check("t1_pkt_count", 64'(pkt_count), 64'd1);

    // 61-byte frame in buffer 2
    base = beats_total;
    post_frame(4'd2, 11'd61);
    wait_acks(2, "t2_ack_seen");
    check("t2_beats", 64'(beats_total - base), 64'd8);
    check("t2_first_addr", 64'(first_rd_addr), 64'h5000);
    check("t2_last_keep", 64'(last_keep_seen), 64'h1F);
    check("t2_ack_wdata", last_ack_wdata, 64'd3);
    check("t2_pkt_count", 64'(pkt_count), 64'd2);

    // Backpressure on the third beat
    base  = beats_total;
    sbase = stall_cycles;
    post_frame(4'd0, 11'd64);
    wait_beats(base + 2, "t3_two_beats");
    m_tready = 1'b0;
    for (int i = 0; i < 100 && !m_tvalid; i++) begin
      @(posedge msoc_clk);
      #2;
    end
    check("t3_valid_rose", 64'(m_tvalid), 64'd1);
    repeat (20) @(posedge msoc_clk);
    #2;
    m_tready = 1'b1;
    wait_acks(3, "t3_ack_seen");
    check("t3_stall_cycles", 64'(stall_cycles - sbase), 64'd20);
    check("t3_beats", 64'(beats_total - base), 64'd8);
    check("t3_pkt_count", 64'(pkt_count), 64'd3);

    // Bad lengths are dropped but still released
    base = beats_total;
    post_frame(4'd3, 11'd0);
    wait_acks(4, "t4a_ack_seen");
    check("t4a_ack_wdata", last_ack_wdata, 64'd4);
    post_frame(4'd5, 11'd1600);
    wait_acks(5, "t4b_ack_seen");
    check("t4b_ack_wdata", last_ack_wdata, 64'd6);
    check("t4_beats", 64'(beats_total - base), 64'd0);
    check("t4_drop_count", 64'(drop_count), 64'd2);
    check("t4_pkt_count", 64'(pkt_count), 64'd3);

    // Nothing received: status polling only
    repeat (40) @(posedge msoc_clk);
    #2;
    poll_window = 1'b1;
    repeat (60) @(posedge msoc_clk);
    #2;
    check("t5_poll_period", 64'(poll_period), 64'd18);
    check("t5_other_access", 64'(other_access), 64'd0);
    check("t5_polls_seen", 64'(rsr_in_window >= 3), 64'd1);
    poll_window = 1'b0;

    // Reset in the middle of a frame, then full re-drain
    base = beats_total;
    post_frame(4'd1, 11'd64);
    wait_beats(base + 4, "t6_four_beats");
    reset = 1'b1;
    @(posedge msoc_clk);
    #2;
    check_quiet("t6_reset");
    @(posedge msoc_clk);
    #1;
    reset = 1'b0;
    wait_acks(6, "t6_ack_seen");
    check("t6_beats", 64'(beats_total - base), 64'd12);
    check("t6_first_addr", 64'(first_rd_addr), 64'h4800);
    check("t6_ack_wdata", last_ack_wdata, 64'd2);
    check("t6_pkt_count", 64'(pkt_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
